// File: rtl/npc_pc_unit_pkg.sv
// Shared encodings for the IF-stage PC unit: branch/jump types, FSM states
// and the default fetch address after reset.
package npc_pc_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_J    = 3'd3,
        BR_JAL  = 3'd4,
        BR_JR   = 3'd5
    } br_type_e;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/npc_pc_unit_npc_calc.sv
// Combinational next-PC resolution: branch condition, target selection and
// the PC value to load on the next clock edge.
module npc_calc
    import npc_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        run,
    input  logic        stall,
    input  logic        d_valid,
    input  logic [2:0]  br_type,
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    input  logic        zero,
    input  logic [31:0] f_pc,
    output logic        resolved,
    output logic        taken,
    output logic [31:0] next_pc,
    output logic [31:0] link_pc
);

    logic        cond;
    logic        is_branch;
    logic [31:0] target;
    logic [31:0] slot_pc;

    always_comb begin
        cond      = 1'b0;
        is_branch = 1'b0;
        target    = 32'h0;
        slot_pc   = d_pc + 32'd4;
        case (br_type)
            BR_BEQ: begin
                is_branch = 1'b1;
                cond      = zero;
                target    = slot_pc + {{14{imm16[15]}}, imm16, 2'b00};
            end
            BR_BNE: begin
                is_branch = 1'b1;
                cond      = ~zero;
                target    = slot_pc + {{14{imm16[15]}}, imm16, 2'b00};
            end
            BR_J, BR_JAL: begin
                is_branch = 1'b1;
                cond      = 1'b1;
                target    = {slot_pc[31:28], instr_index, 2'b00};
            end
            BR_JR: begin
                is_branch = 1'b1;
                cond      = 1'b1;
                target    = rs_val;
            end
            default: begin
                is_branch = 1'b0;
            end
        endcase

        resolved = run && d_valid && !stall && is_branch;
        taken    = resolved && cond;
        link_pc  = d_pc + 32'd8;

        // The delay slot is already at f_pc, so a taken target lands one edge later.
        if (!run)
            next_pc = RESET_PC;
        else if (stall)
            next_pc = f_pc;
        else if (taken)
            next_pc = target;
        else
            next_pc = f_pc + 32'd4;
    end

endmodule

// File: rtl/npc_pc_unit.sv
// IF-stage program counter with boot FSM, delayed-branch redirect and
// taken/total branch statistics counters.
module npc_pc_unit
    import npc_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             d_valid,
    input  logic [2:0]       br_type,
    input  logic [31:0]      d_pc,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      rs_val,
    input  logic             zero,
    output logic [31:0]      f_pc,
    output logic             f_valid,
    output logic             redirect,
    output logic [31:0]      link_pc,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    pc_state_e        state_q, state_d;
    logic [31:0]      f_pc_q, f_pc_d;
    logic             f_valid_q, f_valid_d;
    logic [CNT_W-1:0] br_total_q, br_total_d;
    logic [CNT_W-1:0] br_taken_q, br_taken_d;

    logic             resolved;
    logic             taken;
    logic [31:0]      next_pc;

    npc_calc #(
        .RESET_PC (RESET_PC)
    ) u_npc_calc (
        .run         (state_q == ST_RUN),
        .stall       (stall),
        .d_valid     (d_valid),
        .br_type     (br_type),
        .d_pc        (d_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .zero        (zero),
        .f_pc        (f_pc_q),
        .resolved    (resolved),
        .taken       (taken),
        .next_pc     (next_pc),
        .link_pc     (link_pc)
    );

    always_comb begin
        state_d    = ST_RUN;
        f_valid_d  = 1'b1;
        f_pc_d     = next_pc;
        br_total_d = br_total_q + {{(CNT_W-1){1'b0}}, resolved};
        br_taken_d = br_taken_q + {{(CNT_W-1){1'b0}}, taken};
    end

    // BOOT holds one cycle at RESET_PC with f_valid low to let IMEM settle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            f_pc_q     <= RESET_PC;
            f_valid_q  <= 1'b0;
            br_total_q <= '0;
            br_taken_q <= '0;
        end else begin
            state_q    <= state_d;
            f_pc_q     <= f_pc_d;
            f_valid_q  <= f_valid_d;
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign f_pc     = f_pc_q;
    assign f_valid  = f_valid_q;
    assign redirect = taken;
    assign br_total = br_total_q;
    assign br_taken = br_taken_q;

endmodule

// File: tb/tb_npc_pc_unit.sv
// Self-checking bench for npc_pc_unit: directed delayed-branch scenarios
// followed by randomized traffic against a behavioural PC model.
module tb_npc_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        d_valid;
    logic [2:0]  br_type;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;
    logic        zero;
    logic [31:0] f_pc;
    logic        f_valid;
    logic        redirect;
    logic [31:0] link_pc;
    logic [31:0] br_total;
    logic [31:0] br_taken;

    int total_cnt = 0;
    int bad_cnt   = 0;

    bit          m_run   = 1'b0;
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_total = 32'h0;
    logic [31:0] m_taken = 32'h0;

    always #5 clk = ~clk;

    npc_pc_unit #(
        .RESET_PC (RST_PC),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .d_valid     (d_valid),
        .br_type     (br_type),
        .d_pc        (d_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .zero        (zero),
        .f_pc        (f_pc),
        .f_valid     (f_valid),
        .redirect    (redirect),
        .link_pc     (link_pc),
        .br_total    (br_total),
        .br_taken    (br_taken)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp)
        else begin
            bad_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refTarget(input int kind, input logic [31:0] pc,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] rs);
        int off;
        if (kind == 1 || kind == 2) begin
            off = int'($signed(imm)) * 4;
            return pc + 32'd4 + 32'(off);
        end else if (kind == 3 || kind == 4) begin
            return ((pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4);
        end
        return rs;
    endfunction

    function automatic bit refTaken(input int kind, input logic z);
        if (kind == 1) return z;
        if (kind == 2) return !z;
        return (kind >= 3 && kind <= 5);
    endfunction

    // One clock: drive at negedge, check combinational outputs, then check state after the edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic dv,
                                 input logic [2:0] bt, input logic [31:0] dpc,
                                 input logic [15:0] imm, input logic [25:0] idx,
                                 input logic [31:0] rs, input logic z);
        bit res;
        bit tk;
        int kind;
        @(negedge clk);
        reset = rst; stall = stl; d_valid = dv; br_type = bt;
        d_pc = dpc; imm16 = imm; instr_index = idx; rs_val = rs; zero = z;
        #1;
        kind = int'(bt);
        res  = m_run && dv && !stl && kind >= 1 && kind <= 5;
        tk   = res && refTaken(kind, z);
        checkOutput("redirect", {31'b0, redirect}, {31'b0, tk});
        if (kind == 4)
            checkOutput("link_pc", link_pc, dpc + 32'd8);
        @(posedge clk);
        if (!rst) begin
            m_run = 1'b0; m_pc = RST_PC; m_total = 0; m_taken = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_pc = RST_PC;
        end else if (!stl) begin
            m_pc = tk ? refTarget(kind, dpc, imm, idx, rs) : m_pc + 32'd4;
            if (res) m_total = m_total + 1;
            if (tk)  m_taken = m_taken + 1;
        end
        #1;
        checkOutput("f_pc", f_pc, m_pc);
        checkOutput("f_valid", {31'b0, f_valid}, {31'b0, m_run});
        checkOutput("br_total", br_total, m_total);
        checkOutput("br_taken", br_taken, m_taken);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; d_valid = 1'b0; br_type = 3'd0; d_pc = 32'h0;
        imm16 = 16'h0; instr_index = 26'h0; rs_val = 32'h0; zero = 1'b0;

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 3'd1, 32'h3004, 16'hFFFF, 26'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 32'h3004, 16'h0040, 26'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd4, 32'h3010, 16'h0, 26'h0000C10, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, 32'h3040, 16'h0, 26'h0, 32'h3018, 1'b0);

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, (i < 2), 1'b1, 3'd1, 32'h3018, 16'h0010, 26'h0, 32'h0, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 32'h3020, 16'h0, 26'h0, 32'h1234_5678, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b1, 3'd5, 32'h3000, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
                          32'($urandom), 16'($urandom), 26'($urandom), 32'($urandom),
                          1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
